// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM state encoding,
// destination ID width and the default broadcast ID.
package bus_arb_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at ptr and
// returns the first one found as a one-hot grant plus its index.
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int   cand;
        logic found;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: pops one packet per grant and routes it to its
// destination receiver. Define BUS_ARB_BROADCAST_EN to deliver broadcast packets.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int              DRVRS   = 4,
    parameter int              PCKG_SZ = 16,
    parameter logic [ID_W-1:0] BCAST   = BCAST_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]                pop,
    output logic [DRVRS-1:0]                push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
    output logic                            busy,
    output logic [15:0]                     drop_cnt
);

    localparam int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [PCKG_SZ-1:0] pkt_reg;
    logic [15:0]        drop_q;

    logic [DRVRS-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [ID_W-1:0]    pop_dest;
    logic [ID_W-1:0]    send_dest;

    rr_arbiter #(
        .N     (DRVRS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (pndng),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Receiver mask for a packet from driver g; an all-zero mask means the packet is dropped.
    function automatic logic [DRVRS-1:0] deliver_mask(input logic [ID_W-1:0] d,
                                                      input logic [IDX_W-1:0] g);
        logic [DRVRS-1:0] mask;
        mask = '0;
        if (d == BCAST) begin
`ifdef BUS_ARB_BROADCAST_EN
            mask    = '1;
            mask[g] = 1'b0;
`else
            mask = '0;
`endif
        end else if (int'(d) < DRVRS && d != ID_W'(g)) begin
            mask[d[IDX_W-1:0]] = 1'b1;
        end
        return mask;
    endfunction

    assign pop_dest  = D_pop[gnt_idx][PCKG_SZ-1 -: ID_W];
    assign send_dest = pkt_reg[PCKG_SZ-1 -: ID_W];
    assign D_push    = {DRVRS{pkt_reg}};
    assign drop_cnt  = drop_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pop     <= '0;
            push    <= '0;
            busy    <= 1'b0;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            // NOTE: pkt_reg is a single register, not a memory, so it is cleared with the rest.
            pkt_reg <= '0;
            drop_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge state.
            case (state)
                IDLE: begin
                    if (|pndng) begin
                        state   <= POP;
                        pop     <= arb_grant;
                        gnt_idx <= arb_idx;
                        busy    <= 1'b1;
                    end
                end
                POP: begin
                    state   <= SEND;
                    pop     <= '0;
                    pkt_reg <= D_pop[gnt_idx];
                    push    <= deliver_mask(pop_dest, gnt_idx);
                end
                SEND: begin
                    state  <= IDLE;
                    push   <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (int'(gnt_idx) == DRVRS - 1) ? '0 : gnt_idx + IDX_W'(1);
                    if (deliver_mask(send_dest, gnt_idx) == '0 && drop_q != 16'hFFFF) begin
                        drop_q <= drop_q + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    pop   <= '0;
                    push  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
